spi_slave_stream: RTL and testbench

- Parametrised SPI slave front-end for the register/memory bridge.
- Accepts command+data frames of width DATA_W+2 on MOSI, sampled directly on the system clock while SS_n is low, and presents each completed frame as a parallel word with a one-cycle rx_valid.
- For read-data commands, waits for the back-end's tx_valid, then shifts DATA_W bits out on MISO.
- Successor block adds:
  - configurable data width and bit order;
  - back-to-back frames within one SS_n assertion;
  - a tx_valid timeout;
  - an abort/error report.

---
 rtl/spi_slave_stream_if.sv | 25 ++
 rtl/spi_slave_stream.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_stream.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_stream_if.sv
// Bus bundle between an SPI master/back-end pair and spi_slave_stream.
// The slave modport is the DUT view. The master modport is the pin/back-end driver view.
interface spi_slave_stream_if #(
    parameter int DATA_W = 8
) ();
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_stream.sv
// SPI slave front-end: receives command+payload frames on MOSI and optionally returns a
// back-end payload on MISO. Supports back-to-back frames, a tx_valid timeout and abort reporting.
module spi_slave_stream #(
    parameter int         DATA_W     = 8,
    parameter int         MSB_FIRST  = 1,
    parameter logic [1:0] READ_CMD   = 2'b11,
    parameter int         TX_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_slave_stream_if.slave  bus
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SEND_W  = $clog2(DATA_W + 1);
    localparam int TO_W    = $clog2(TX_TIMEOUT + 2);
    localparam int TO_LAST = (TX_TIMEOUT > 0) ? (TX_TIMEOUT - 1) : 0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECV    = 2'd1;
    localparam logic [1:0] WAIT_TX = 2'd2;
    localparam logic [1:0] SEND    = 2'd3;

    logic [1:0]         state_r,    state_s;
    logic [FRAME_W-1:0] shift_r,    shift_s;
    logic [FRAME_W-1:0] frame_in_s;
    logic [CNT_W-1:0]   cnt_r,      cnt_s;
    logic [TO_W-1:0]    to_cnt_r,   to_cnt_s;
    logic [DATA_W-1:0]  tx_shift_r, tx_shift_s;
    logic [SEND_W-1:0]  send_cnt_r, send_cnt_s;
    logic               miso_r,     miso_s;
    logic [FRAME_W-1:0] rx_data_r,  rx_data_s;
    logic               rx_valid_r, rx_valid_s;
    logic               frame_err_r, frame_err_s;
    logic               busy_r,     busy_s;

    // Next-state and datapath decode; an SS_n release outside IDLE overrides all other events.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        to_cnt_s    = to_cnt_r;
        tx_shift_s  = tx_shift_r;
        send_cnt_s  = send_cnt_r;
        miso_s      = miso_r;
        rx_data_s   = rx_data_r;
        rx_valid_s  = 1'b0;
        frame_err_s = 1'b0;

        if (MSB_FIRST != 0) begin
            frame_in_s = {shift_r[FRAME_W-2:0], bus.MOSI};
        end else begin
            frame_in_s = {bus.MOSI, shift_r[FRAME_W-1:1]};
        end

        if ((state_r != IDLE) && bus.SS_n) begin
            state_s     = IDLE;
            miso_s      = 1'b0;
            cnt_s       = CNT_W'(0);
            to_cnt_s    = TO_W'(0);
            send_cnt_s  = SEND_W'(0);
            frame_err_s = (state_r != RECV) || (cnt_r != CNT_W'(0));
        end else begin
            case (state_r)
                IDLE: begin
                    miso_s = 1'b0;
                    if (!bus.SS_n) begin
                        if (MSB_FIRST != 0) begin
                            shift_s = {{(FRAME_W-1){1'b0}}, bus.MOSI};
                        end else begin
                            shift_s = {bus.MOSI, {(FRAME_W-1){1'b0}}};
                        end
                        cnt_s   = CNT_W'(1);
                        state_s = RECV;
                    end else begin
                        cnt_s   = CNT_W'(0);
                    end
                end

                RECV: begin
                    shift_s = frame_in_s;
                    if (cnt_r == CNT_W'(FRAME_W - 1)) begin
                        rx_data_s  = frame_in_s;
                        rx_valid_s = 1'b1;
                        cnt_s      = CNT_W'(0);
                        to_cnt_s   = TO_W'(0);
                        if (frame_in_s[FRAME_W-1 -: 2] == READ_CMD) begin
                            state_s = WAIT_TX;
                        end else begin
                            state_s = RECV;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end

                // tx_valid is checked before the timeout so it wins a same-edge race.
                WAIT_TX: begin
                    if (bus.tx_valid) begin
                        if (MSB_FIRST != 0) begin
                            miso_s     = bus.tx_data[DATA_W-1];
                            tx_shift_s = {bus.tx_data[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_s     = bus.tx_data[0];
                            tx_shift_s = {1'b0, bus.tx_data[DATA_W-1:1]};
                        end
                        send_cnt_s = SEND_W'(1);
                        to_cnt_s   = TO_W'(0);
                        state_s    = SEND;
                    end else if ((TX_TIMEOUT != 0) && (to_cnt_r == TO_W'(TO_LAST))) begin
                        frame_err_s = 1'b1;
                        to_cnt_s    = TO_W'(0);
                        cnt_s       = CNT_W'(0);
                        state_s     = RECV;
                    end else begin
                        to_cnt_s = to_cnt_r + TO_W'(1);
                    end
                end

                SEND: begin
                    if (send_cnt_r == SEND_W'(DATA_W)) begin
                        miso_s     = 1'b0;
                        send_cnt_s = SEND_W'(0);
                        cnt_s      = CNT_W'(0);
                        state_s    = RECV;
                    end else begin
                        if (MSB_FIRST != 0) begin
                            miso_s     = tx_shift_r[DATA_W-1];
                            tx_shift_s = {tx_shift_r[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_s     = tx_shift_r[0];
                            tx_shift_s = {1'b0, tx_shift_r[DATA_W-1:1]};
                        end
                        send_cnt_s = send_cnt_r + SEND_W'(1);
                    end
                end

                default: begin
                    state_s = IDLE;
                    miso_s  = 1'b0;
                    cnt_s   = CNT_W'(0);
                end
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shift_r     <= {FRAME_W{1'b0}};
            cnt_r       <= CNT_W'(0);
            to_cnt_r    <= TO_W'(0);
            tx_shift_r  <= {DATA_W{1'b0}};
            send_cnt_r  <= SEND_W'(0);
            miso_r      <= 1'b0;
            rx_data_r   <= {FRAME_W{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            cnt_r       <= cnt_s;
            to_cnt_r    <= to_cnt_s;
            tx_shift_r  <= tx_shift_s;
            send_cnt_r  <= send_cnt_s;
            miso_r      <= miso_s;
            rx_data_r   <= rx_data_s;
            rx_valid_r  <= rx_valid_s;
            frame_err_r <= frame_err_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.MISO      = miso_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: an MSB-first instance with a 16-cycle timeout,
// plus an LSB-first instance for bit-order checks.
module tb_spi_slave_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    spi_slave_stream_if #(.DATA_W(8)) bus ();
    spi_slave_stream_if #(.DATA_W(8)) bus_l ();

    spi_slave_stream #(.DATA_W(8), .MSB_FIRST(1), .READ_CMD(2'b11), .TX_TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    spi_slave_stream #(.DATA_W(8), .MSB_FIRST(0), .READ_CMD(2'b11), .TX_TIMEOUT(16)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bus_l.slave));

    int n_cmp = 0;
    int n_err = 0;

    // Record every rx_valid pulse (cycle and data) and every frame_err pulse of the MSB instance.
    int         rv_cyc[$];
    logic [9:0] rv_data[$];
    int         fe_cnt = 0;
    int         both_cnt = 0;
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            rv_cyc.push_back(cyc);
            rv_data.push_back(bus.rx_data);
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
        if ((bus.rx_valid === 1'b1) && (bus.frame_err === 1'b1)) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive n frame bits, one per clock, starting at the current negedge; returns on the
    // negedge after the last sampling edge.
    task automatic send_bits(input logic [9:0] f, input int n, input bit lsb);
        for (int i = 0; i < n; i++) begin
            if (lsb) begin
                bus_l.SS_n = 1'b0;
                bus_l.MOSI = f[i];
            end else begin
                bus.SS_n = 1'b0;
                bus.MOSI = f[9-i];
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [9:0] frame;
        logic [9:0] exp_rx;
    } wr_vec_t;

    typedef struct {
        int         delay;
        logic [7:0] tx;
        logic [7:0] exp_miso;
    } rd_vec_t;

    wr_vec_t wr_tab[5];
    rd_vec_t rd_tab[3];

    task automatic do_read(input rd_vec_t v);
        send_bits(10'b11_0000_0000, 10, 1'b0);
        check("rd_rxv", {31'd0, bus.rx_valid}, 32'd1);
        check("rd_rxdata", {22'd0, bus.rx_data}, 32'h300);
        bus.MOSI = 1'b1;
        repeat (v.delay - 1) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = v.tx;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        check("rd_noerr", {31'd0, bus.frame_err}, 32'd0);
        for (int j = 7; j >= 0; j--) begin
            check($sformatf("rd_miso_%0d", 7 - j), {31'd0, bus.MISO}, {31'd0, v.exp_miso[j]});
            check("rd_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        check("rd_miso_end", {31'd0, bus.MISO}, 32'd0);
        check("rd_busy_end", {31'd0, bus.busy}, 32'd1);
    endtask

    int  rv0;
    int  fe0;
    int  early;
    logic [7:0] lsb_exp;

    initial begin
        wr_tab[0] = '{10'b00_1010_0101, 10'h0A5};
        wr_tab[1] = '{10'b01_1111_0000, 10'h1F0};
        wr_tab[2] = '{10'b10_0000_0001, 10'h201};
        wr_tab[3] = '{10'b10_1111_1111, 10'h2FF};
        wr_tab[4] = '{10'b01_0101_1010, 10'h15A};
        rd_tab[0] = '{3,  8'hC3, 8'b1100_0011};
        rd_tab[1] = '{1,  8'h96, 8'b1001_0110};
        rd_tab[2] = '{16, 8'hA5, 8'b1010_0101};

        rst_n = 1'b0;
        bus.SS_n = 1'b1;   bus.MOSI = 1'b0;   bus.tx_valid = 1'b0;   bus.tx_data = 8'h00;
        bus_l.SS_n = 1'b1; bus_l.MOSI = 1'b0; bus_l.tx_valid = 1'b0; bus_l.tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_miso", {31'd0, bus.MISO}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_rxv", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_rxdata", {22'd0, bus.rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write frame, then SS_n release in RECV with count 0.
        send_bits(10'b00_1010_0101, 10, 1'b0);
        check("w1_rxv", {31'd0, bus.rx_valid}, 32'd1);
        check("w1_rxdata", {22'd0, bus.rx_data}, 32'h0A5);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("w1_rxv_pulse", {31'd0, bus.rx_valid}, 32'd0);
        check("w1_noerr", {31'd0, bus.frame_err}, 32'd0);
        check("w1_idle", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Back-to-back write frames from the table in one SS_n assertion.
        rv0 = rv_cyc.size();
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_bits(wr_tab[i].frame, 10, 1'b0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("b2b_count", rv_cyc.size() - rv0, 32'd5);
        if (rv_cyc.size() >= rv0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("b2b_data_%0d", i), {22'd0, rv_data[rv0+i]}, {22'd0, wr_tab[i].exp_rx});
                if (i > 0) check($sformatf("b2b_gap_%0d", i), rv_cyc[rv0+i] - rv_cyc[rv0+i-1], 32'd10);
            end
        end
        check("b2b_noerr", fe_cnt - fe0, 32'd0);
        repeat (2) @(negedge clk);

        // Reads from the table, including tx_valid racing the timeout edge.
        fe0 = fe_cnt;
        for (int i = 0; i < 3; i++) do_read(rd_tab[i]);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("rd_noerr_total", fe_cnt - fe0, 32'd0);
        check("rd_idle", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Timeout, then the next 10 bits must still form a frame.
        send_bits(10'b11_0000_0000, 10, 1'b0);
        check("to_rxv", {31'd0, bus.rx_valid}, 32'd1);
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.frame_err !== 1'b0) early++;
        end
        check("to_not_early", early, 32'd0);
        @(negedge clk);
        check("to_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("to_busy", {31'd0, bus.busy}, 32'd1);
        send_bits(10'b00_1100_0011, 10, 1'b0);
        check("to_next_rxv", {31'd0, bus.rx_valid}, 32'd1);
        check("to_next_data", {22'd0, bus.rx_data}, 32'h0C3);
        bus.SS_n = 1'b1;
        repeat (3) @(negedge clk);

        // Abort after 5 bits.
        rv0 = rv_cyc.size();
        send_bits(10'b10_1010_1010, 5, 1'b0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("ab5_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("ab5_idle", {31'd0, bus.busy}, 32'd0);
        check("ab5_rxdata", {22'd0, bus.rx_data}, 32'h0C3);
        @(negedge clk);
        check("ab5_ferr_pulse", {31'd0, bus.frame_err}, 32'd0);
        check("ab5_norxv", rv_cyc.size() - rv0, 32'd0);

        // SS_n rises on the edge that would sample the last bit: abort wins.
        send_bits(10'b01_1111_0000, 9, 1'b0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("ablast_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("ablast_norxv", {31'd0, bus.rx_valid}, 32'd0);
        check("ablast_rxdata", {22'd0, bus.rx_data}, 32'h0C3);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of SEND.
        send_bits(10'b11_0000_0000, 10, 1'b0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check("rs_miso_pre", {31'd0, bus.MISO}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_miso", {31'd0, bus.MISO}, 32'd0);
        check("rs_busy", {31'd0, bus.busy}, 32'd0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rs_after", {31'd0, bus.busy}, 32'd0);

        // LSB-first instance: write then back-to-back read with tx_data 8'h01.
        send_bits(10'h1A5, 10, 1'b1);
        check("lsb_w_rxv", {31'd0, bus_l.rx_valid}, 32'd1);
        check("lsb_w_data", {22'd0, bus_l.rx_data}, 32'h1A5);
        send_bits(10'h300, 10, 1'b1);
        check("lsb_r_data", {22'd0, bus_l.rx_data}, 32'h300);
        bus_l.tx_valid = 1'b1;
        bus_l.tx_data  = 8'h01;
        @(negedge clk);
        bus_l.tx_valid = 1'b0;
        lsb_exp = 8'b1000_0000;
        for (int j = 7; j >= 0; j--) begin
            check($sformatf("lsb_miso_%0d", 7 - j), {31'd0, bus_l.MISO}, {31'd0, lsb_exp[j]});
            @(negedge clk);
        end
        check("lsb_miso_end", {31'd0, bus_l.MISO}, 32'd0);
        bus_l.SS_n = 1'b1;
        repeat (2) @(negedge clk);

        check("rxv_ferr_excl", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
